// File: rtl/wb_ps2_pkg.sv
// rtl/wb_ps2_pkg.sv - shared register map, flag bit positions and receive FSM states
package wb_ps2_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    localparam int ST_NOT_EMPTY  = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERRUN    = 2;
    localparam int ST_PARITY_ERR = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_TIMEOUT    = 5;

    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - synchronous byte FIFO with wrap-bit pointers for received scan codes
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [7:0]                    wdata,
    output logic [7:0]                    rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // A push into a full FIFO only lands when a pop frees the slot in the same cycle
    assign w_do_push = push & ~flush & (~full | pop);
    assign w_do_pop  = pop & ~flush & ~empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    assign rdata = empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush wins over any push or pop in the same cycle
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write, no reset needed since pointers qualify every read
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wb_ps2_rx.sv
// rtl/wb_ps2_rx.sv - Wishbone PS/2 receiver top; optional watchdog via WB_PS2_RX_TIMEOUT_EN
module wb_ps2_rx
    import wb_ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] addr_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       ack_o,
    output logic       irq_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]   r_clk_sync;
    logic [1:0]   r_dat_sync;
    logic         r_filt;
    logic [FCW-1:0] r_fcnt;
    logic         r_fall;
    logic         r_din;

    rx_state_t    r_state;
    rx_state_t    w_state_nxt;
    logic [7:0]   r_shift;
    logic [2:0]   r_bitcnt;
    logic         r_par;
    logic         w_push;
    logic         w_set_par;
    logic         w_set_frm;
    logic         w_timeout;
    logic         w_to_flag;

    logic         r_ack;
    logic [7:0]   r_data_o;
    logic         r_rx_en;
    logic         r_irq_en;
    logic         r_flush;
    logic         r_ovr;
    logic         r_par_err;
    logic         r_frm_err;

    logic         w_req;
    logic         w_wr;
    logic         w_rd;
    logic         w_pop;
    logic         w_clr_en;
    logic [7:0]   w_rdata;
    logic [7:0]   w_status;
    logic [7:0]   w_ctrl;
    logic [7:0]   w_fifo_rdata;
    logic         w_full;
    logic         w_empty;
    logic [LW-1:0] w_level;
    logic [8:0]   w_level9;
    logic         w_unused_data;

    assign w_unused_data = ^data_i[7:6];

    // Two-stage synchronizers; idle lines are pulled high
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
            r_dat_sync <= {r_dat_sync[0], ps2_data_i};
        end
    end

    // Clock glitch filter: flip only after FILTER_LEN consecutive differing samples, flag falls
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_filt <= 1'b1;
            r_fcnt <= '0;
            r_fall <= 1'b0;
            r_din  <= 1'b1;
        end else if (r_clk_sync[1] == r_filt) begin
            r_fcnt <= '0;
            r_fall <= 1'b0;
        end else if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
            r_filt <= r_clk_sync[1];
            r_fcnt <= '0;
            r_fall <= ~r_clk_sync[1];
            r_din  <= r_dat_sync[1];
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
            r_fall <= 1'b0;
        end
    end

`ifdef WB_PS2_RX_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] r_wdog;
    logic           r_to_err;

    assign w_timeout = r_rx_en && (r_state != RX_IDLE) && (r_wdog == TOW'(TIMEOUT_CYCLES - 1)) && !r_fall;
    assign w_to_flag = r_to_err;

    // Mid-frame watchdog, restarted by every accepted falling edge
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !r_rx_en || r_state == RX_IDLE || r_fall || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + TOW'(1);
        end
    end

    // Sticky timeout flag, write-one-to-clear
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_to_err <= 1'b0;
        end else if (w_timeout) begin
            r_to_err <= 1'b1;
        end else if (w_clr_en && data_i[ST_TIMEOUT]) begin
            r_to_err <= 1'b0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout = 1'b0;
    assign w_to_flag = 1'b0;
`endif

    // Frame FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= RX_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Frame FSM next state and end-of-frame verdict
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_set_par   = 1'b0;
        w_set_frm   = 1'b0;
        if (!r_rx_en || w_timeout) begin
            w_state_nxt = RX_IDLE;
        end else if (r_fall) begin
            unique case (r_state)
                RX_IDLE:   if (!r_din) w_state_nxt = RX_DATA;
                RX_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = RX_PARITY;
                RX_PARITY: w_state_nxt = RX_STOP;
                RX_STOP: begin
                    w_state_nxt = RX_IDLE;
                    if (!r_din)                   w_set_frm = 1'b1;
                    else if (^{r_shift, r_par})   w_push    = 1'b1;
                    else                          w_set_par = 1'b1;
                end
                default:   w_state_nxt = RX_IDLE;
            endcase
        end
    end

    // Frame datapath: LSB-first shift register, bit counter and parity capture
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_par    <= 1'b0;
        end else if (!r_rx_en || w_timeout) begin
            r_bitcnt <= 3'd0;
        end else if (r_fall) begin
            unique case (r_state)
                RX_IDLE:   r_bitcnt <= 3'd0;
                RX_DATA: begin
                    r_shift  <= {r_din, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
                RX_PARITY: r_par <= r_din;
                default:   r_bitcnt <= 3'd0;
            endcase
        end
    end

    assign w_req    = cyc_i & stb_i & ~r_ack;
    assign w_wr     = w_req & we_i;
    assign w_rd     = w_req & ~we_i;
    assign w_pop    = w_rd & (addr_i == REG_DATA);
    assign w_clr_en = w_wr & (addr_i == REG_STATUS);

    ps2_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (r_flush),
        .wdata   (r_shift),
        .rdata   (w_fifo_rdata),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    assign w_level9 = 9'(w_level);

    // Register read view
    always_comb begin
        w_status                = 8'h00;
        w_status[ST_NOT_EMPTY]  = ~w_empty;
        w_status[ST_FULL]       = w_full;
        w_status[ST_OVERRUN]    = r_ovr;
        w_status[ST_PARITY_ERR] = r_par_err;
        w_status[ST_FRAME_ERR]  = r_frm_err;
        w_status[ST_TIMEOUT]    = w_to_flag;
        w_ctrl                  = 8'h00;
        w_ctrl[CTRL_RX_EN]      = r_rx_en;
        w_ctrl[CTRL_IRQ_EN]     = r_irq_en;
        w_rdata                 = 8'h00;
        unique case (addr_i)
            REG_DATA:   w_rdata = w_fifo_rdata;
            REG_STATUS: w_rdata = w_status;
            REG_CTRL:   w_rdata = w_ctrl;
            REG_LEVEL:  w_rdata = (w_level9 > 9'd255) ? 8'hFF : w_level9[7:0];
            default:    w_rdata = 8'h00;
        endcase
    end

    // Bus handshake: one-cycle registered ack with read data captured alongside
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ack    <= 1'b0;
            r_data_o <= 8'h00;
        end else begin
            r_ack    <= w_req;
            r_data_o <= w_rd ? w_rdata : 8'h00;
        end
    end

    // Control register; flush is a one-cycle pulse following the write
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rx_en  <= 1'b0;
            r_irq_en <= 1'b0;
            r_flush  <= 1'b0;
        end else if (w_wr && addr_i == REG_CTRL) begin
            r_rx_en  <= data_i[CTRL_RX_EN];
            r_irq_en <= data_i[CTRL_IRQ_EN];
            r_flush  <= data_i[CTRL_FLUSH];
        end else begin
            r_flush  <= 1'b0;
        end
    end

    // Sticky error flags; a new event in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ovr     <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_ovr     <= (w_push & w_full & ~w_pop & ~r_flush) |
                         (r_ovr & ~(w_clr_en & data_i[ST_OVERRUN]));
            r_par_err <= w_set_par | (r_par_err & ~(w_clr_en & data_i[ST_PARITY_ERR]));
            r_frm_err <= w_set_frm | (r_frm_err & ~(w_clr_en & data_i[ST_FRAME_ERR]));
        end
    end

    assign data_o = r_data_o;
    assign ack_o  = r_ack;
    assign irq_o  = r_irq_en & (~w_empty | r_ovr | r_par_err | r_frm_err | w_to_flag);

endmodule

// File: doc/wb_ps2_rx.md
# wb_ps2_rx

Parametrised Wishbone slave receiving PS/2 keyboard scan codes into a buffered FIFO, with status flags and an interrupt output. It is the successor to the single-register PS/2 port. It sits on the 8-bit Wishbone peripheral bus between the board's PS/2 connector and the CPU. It adds:
- clock filtering,
- full frame decoding,
- error reporting,
- a configurable-depth receive buffer.

## Interface
- FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256
- FILTER_LEN, 8, clk_i cycles ps2_clk must stay stable before a level change is accepted
- TIMEOUT_CYCLES, 100000, clk_i cycles of no falling edge mid-frame before abort (2 ms at 50 MHz)

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_n_i  in  1  synchronous, active-low reset
- addr_i  in  2  register select
- cyc_i, stb_i, we_i  in  1 each  Wishbone cycle, strobe, write enable
- data_i  in  8  write data
- data_o  out  8  read data
- ack_o  out  1  Wishbone acknowledge
- irq_o  out  1  level interrupt
- ps2_clk_i, ps2_data_i  in  1 each  asynchronous PS/2 lines; open-collector, externally pulled up

## Operation
Registers:
- 0 DATA (R): pops the FIFO head. Reads 0x00 with no pointer change when the FIFO is empty. Writes are ignored.
- 1 STATUS:
  - bit0 not_empty, bit1 full
  - sticky flags: bit2 overrun, bit3 parity_err, bit4 frame_err, bit5 timeout
  - writing 1 to a sticky bit clears it
- 2 CTRL (RW): bit0 rx_en, bit1 irq_en, bit2 flush. Flush is self-clearing: it empties the FIFO in the cycle after the write and always reads 0.
- 3 LEVEL (R): FIFO occupancy, saturating at 255.

Input path:
- 2-FF synchronizer on both PS/2 lines.
- Filter on clock: the filtered clock changes only after FILTER_LEN consecutive equal samples.
- A falling edge of the filtered clock samples the synchronized data line.

Frame FSM (11-bit frame, LSB first). States are IDLE, DATA, PARITY, STOP.
- IDLE: on edge with data=0 → DATA, bit counter=0. With data=1, stay in IDLE.
- DATA: shift the bit in. After the 8th bit → PARITY.
- PARITY: capture the bit → STOP.
- STOP: the frame is checked, then the FSM returns to IDLE.
  - data=1 and odd parity correct: push the byte.
  - bad parity: set parity_err, discard the byte.
  - data=0: set frame_err, discard the byte.
- rx_en=0 holds the FSM in IDLE and discards any partial frame.

FIFO rules:
- Push while full with no simultaneous pop: the byte is dropped and overrun is set.
- Push and pop in the same cycle:
  - When full, both occur and overrun is not set.
  - When empty, the pop returns 0x00 and the push lands.
- Flush takes priority over a simultaneous push.

irq_o = irq_en & (not_empty | any sticky flag).

Reset values:
- data_o=0, ack_o=0, irq_o=0.
- FIFO empty, all flags 0, CTRL=0 (receiver disabled).
- FSM in IDLE, filter state = high.

## Timing
- ack_o is registered. It is asserted one cycle after cyc_i&stb_i, for exactly one cycle, and deasserts the following cycle even if the strobe persists.
- Register writes and the FIFO pop take effect on the ack cycle edge. data_o is valid while ack_o is high.
- ps2_clk_i edge to FSM action is 2 (sync) + FILTER_LEN + 1 clk_i cycles.
- The FIFO push happens 1 cycle after the stop-bit edge. not_empty and irq_o assert on the following cycle.
- rst_n_i low mid-frame: everything returns to reset values at the next edge, and the partial frame is lost.

## Configuration
- Macro: WB_PS2_RX_TIMEOUT_EN.
- Defined: a watchdog counts clk_i cycles while the FSM is not in IDLE and resets on each accepted falling edge. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the partial byte is discarded, and timeout is set.
- Undefined: no counter is built, STATUS bit5 reads 0, and a stalled frame waits indefinitely.

## Structure
- Package wb_ps2_pkg holds:
  - register address constants (REG_DATA..REG_LEVEL)
  - STATUS and CTRL bit positions
  - the FSM state enum
- Sub-module ps2_rx_fifo: a synchronous FIFO parametrised by FIFO_DEPTH.
  - Ports: push, pop, flush, wdata, rdata, full, empty, level.
  - It keeps an extra wrap bit on its pointers.

## Test plan
- Reset, then read STATUS, CTRL and LEVEL → all 0x00; irq_o=0, ack_o=0.
- rx_en=1, irq_en=1; send frame 0x1C with correct parity → LEVEL=1, irq_o=1; DATA read → 0x1C, then LEVEL=0 and irq_o=0.
- Send 0x5A with wrong parity → FIFO still empty, STATUS=0x08; write 0x08 to STATUS → STATUS=0x00.
- Send FIFO_DEPTH+1 bytes 0x01..0x11 → full=1, overrun=1; reads return 0x01..0x10 in order.
- Inject 3-cycle glitch pulses on ps2_clk_i mid-frame → no bit is sampled and the received byte is unchanged.
- With WB_PS2_RX_TIMEOUT_EN, stop the PS/2 clock after 4 data bits → timeout=1 after TIMEOUT_CYCLES; the next full frame is received correctly.
